// File: rtl/addsub_seq_ctrl.sv
// Multi-word add/subtract sequencer: one 4-bit ripple slice iterated over the
// operand nibbles LSB first, with the inter-nibble carry held in a register.
module addsub_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovfl,
    output logic                   busy
);

    // state  | meaning
    // S_IDLE | waiting for an operation, in_ready high
    // S_RUN  | computing one nibble per cycle
    // S_DONE | result held until the consumer takes it
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovfl;
    logic            r_out_valid;
    logic            r_busy;

    logic            w_accept;
    logic            w_run;
    logic            w_last;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_bx_nib;
    logic [3:0]      w_s_nib;
    logic [4:0]      w_c;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_idx == LAST);

    assign w_a_nib  = 4'(r_a >> {r_idx, 2'b00});
    assign w_bx_nib = 4'(r_b >> {r_idx, 2'b00}) ^ {4{r_sub}};
    assign w_c[0]   = r_carry;

    for (genvar k = 0; k < 4; k++) begin : g_full_adder_1bit
        assign w_s_nib[k] = w_a_nib[k] ^ w_bx_nib[k] ^ w_c[k];
        assign w_c[k+1]   = (w_a_nib[k] & w_bx_nib[k]) |
                            (w_c[k] & (w_a_nib[k] ^ w_bx_nib[k]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovfl      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_sub   <= sub;
                r_carry <= sub;
                r_idx   <= '0;
                r_sum   <= '0;
                r_cout  <= 1'b0;
                r_ovfl  <= 1'b0;
            end else if (w_run) begin
                // sum was cleared on accept, so OR-ing each slice in is enough
                r_sum   <= r_sum | (W'(w_s_nib) << {r_idx, 2'b00});
                r_carry <= w_c[4];
                r_idx   <= r_idx + IDXW'(1);
                if (w_last) begin
                    r_cout <= w_c[4];
                    r_ovfl <= w_c[3] ^ w_c[4];
                end
            end
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovfl      = r_ovfl;

endmodule
